// File: rtl/cpu_pkg.sv
// cpu_pkg: constants and types shared by the MIPS pipeline blocks.
//   RESET_PC      - first fetch address after reset
//   NOP_WORD      - bubble word driven by the fetch stage when it has no instruction
//   fetch_state_t - fetch front-end FSM states (also used by trace printing)
//   word_align    - clears the byte-offset bits of an address
package cpu_pkg;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    typedef enum logic {
        FETCH = 1'b0,
        DROP  = 1'b1
    } fetch_state_t;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & ~32'd3;
    endfunction

endpackage

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: fetch-stage front end. Owns the PC, issues one instruction
// memory request at a time over req/ack, and holds the returned word in a
// one-entry buffer that feeds the IF/ID register.
//
// Ports:
//   clk, reset        - clock; synchronous active-high reset
//   stall             - IF/ID hold; buffered instruction is not consumed
//   redirect_valid/pc - flush and restart fetch at redirect_pc (bits [1:0] ignored)
//   imem_req/addr     - memory request; held stable until imem_ack
//   imem_ack/rdata    - memory completes the current request with this word
//   F_Instruction     - buffered instruction, or NOP_WORD when empty
//   F_PC              - PC of the buffered (or last loaded) instruction
//   F_valid           - buffer holds a real instruction
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = cpu_pkg::RESET_PC,
    parameter logic [31:0] NOP_WORD = cpu_pkg::NOP_WORD
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] F_Instruction,
    output logic [31:0] F_PC,
    output logic        F_valid
);

    cpu_pkg::fetch_state_t r_state;
    cpu_pkg::fetch_state_t w_state_nxt;

    logic [31:0] r_pc;
    logic [31:0] r_tgt;
    logic [31:0] r_buf_inst;
    logic [31:0] r_buf_pc;
    logic        r_buf_valid;
    logic        r_busy;        // request raised in an earlier cycle, not yet acked

    logic [31:0] w_redirect_tgt;
    logic        w_req;
    logic        w_ack;

    assign w_redirect_tgt = cpu_pkg::word_align(redirect_pc);

    // A new request starts only when the buffer will have room at the next
    // edge and no redirect is pending; an outstanding one is held until ack.
    // r_busy is always set in DROP, so DROP keeps the old request alive.
    assign w_req = !reset &&
                   (r_busy ||
                    (r_state == cpu_pkg::FETCH && (!r_buf_valid || !stall) && !redirect_valid));
    assign w_ack = w_req && imem_ack;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= cpu_pkg::FETCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            cpu_pkg::FETCH: begin
                // Redirect against an un-acked request: wait for it to drain.
                if (redirect_valid && r_busy && !imem_ack) begin
                    w_state_nxt = cpu_pkg::DROP;
                end
            end
            cpu_pkg::DROP: begin
                if (w_ack) begin
                    w_state_nxt = cpu_pkg::FETCH;
                end
            end
            default: w_state_nxt = cpu_pkg::FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc        <= RESET_PC;
            r_tgt       <= '0;
            r_buf_inst  <= '0;
            r_buf_pc    <= '0;
            r_buf_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_busy <= w_req && !imem_ack;

            // PC / pending target
            if (r_state == cpu_pkg::DROP) begin
                if (redirect_valid) begin
                    r_tgt <= w_redirect_tgt;
                end
                // A redirect arriving with the draining ack still wins.
                if (w_ack) begin
                    r_pc <= redirect_valid ? w_redirect_tgt : r_tgt;
                end
            end else if (redirect_valid) begin
                if (!r_busy || imem_ack) begin
                    r_pc <= w_redirect_tgt;
                end else begin
                    r_tgt <= w_redirect_tgt;
                end
            end else if (w_ack) begin
                r_pc <= r_pc + 32'd4;
            end

            // Output buffer: flushed by redirect and throughout DROP; an ack
            // reloads it even while the current entry is being consumed.
            if (redirect_valid || r_state == cpu_pkg::DROP) begin
                r_buf_valid <= 1'b0;
            end else if (w_ack) begin
                r_buf_inst  <= imem_rdata;
                r_buf_pc    <= r_pc;
                r_buf_valid <= 1'b1;
            end else if (!stall) begin
                r_buf_valid <= 1'b0;
            end
        end
    end

    assign imem_req      = w_req;
    assign imem_addr     = r_pc;
    assign F_Instruction = r_buf_valid ? r_buf_inst : NOP_WORD;
    assign F_PC          = r_buf_pc;
    assign F_valid       = r_buf_valid;

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb_if_fetch_unit: scoreboard bench for if_fetch_unit. A behavioural memory
// with programmable ack latency answers requests; every word the fetch unit
// should deliver is queued when acked and compared when it shows up on
// F_Instruction/F_PC. Scenario tasks add inline request/address checks.
module tb_if_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] F_Instruction;
    logic [31:0] F_PC;
    logic        F_valid;

    int          vectors    = 0;
    int          miscompares = 0;
    int unsigned lat        = 0;
    int unsigned mem_wait   = 0;
    logic        model_drop = 1'b0;
    bit          mon_en     = 1'b0;
    logic [63:0] sb_q[$];
    logic [63:0] sb_exp;

    if_fetch_unit dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .F_Instruction (F_Instruction),
        .F_PC          (F_PC),
        .F_valid       (F_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    // One clock cycle: memory responds, scoreboard bookkeeping, then the edge.
    task automatic step();
        #1;
        if (imem_req && mem_wait >= lat) begin
            imem_ack   = 1'b1;
            imem_rdata = inst_of(imem_addr);
        end else begin
            imem_ack   = 1'b0;
            imem_rdata = 32'hDEAD_BEEF;
        end
        #1;
        if (reset) begin
            sb_q.delete();
            model_drop = 1'b0;
        end else begin
            if (sb_q.size() != 0 && (!stall || redirect_valid))
                void'(sb_q.pop_front());
            if (imem_ack) begin
                if (model_drop)
                    model_drop = 1'b0;
                else if (!redirect_valid)
                    sb_q.push_back({imem_addr, imem_rdata});
            end else if (redirect_valid && imem_req) begin
                model_drop = 1'b1;
            end
        end
        mem_wait = (imem_req && !imem_ack) ? mem_wait + 1 : 0;
        @(posedge clk);
        @(negedge clk);
        imem_ack = 1'b0;
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            vectors++;
            if (F_valid !== (sb_q.size() != 0)) begin
                miscompares++;
                $display("FAIL sb_valid: got %b expected %b", F_valid, sb_q.size() != 0);
            end
            vectors++;
            if (sb_q.size() != 0) begin
                sb_exp = sb_q[0];
                if ({F_PC, F_Instruction} !== sb_exp) begin
                    miscompares++;
                    $display("FAIL sb_data: got pc=%h inst=%h expected pc=%h inst=%h",
                             F_PC, F_Instruction, sb_exp[63:32], sb_exp[31:0]);
                end
            end else if (F_Instruction !== 32'h0) begin
                miscompares++;
                $display("FAIL sb_nop: got %h expected %h", F_Instruction, 32'h0);
            end
        end
    end

    task automatic reset_dut();
        reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; lat = 0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_pc = '0; lat = 0;
        imem_ack = 1'b0; imem_rdata = '0;
        step();
        mon_en = 1'b1;
        #1;
        vectors += 4;
        if (imem_req !== 1'b0) begin miscompares++; $display("FAIL rst_req: got %b expected 0", imem_req); end
        if (F_Instruction !== 32'h0) begin miscompares++; $display("FAIL rst_inst: got %h expected 0", F_Instruction); end
        if (F_PC !== 32'h0) begin miscompares++; $display("FAIL rst_pc: got %h expected 0", F_PC); end
        if (F_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid: got %b expected 0", F_valid); end
        step();
        reset = 1'b0;
        #1;
        vectors += 2;
        if (imem_req !== 1'b1) begin miscompares++; $display("FAIL rst_first_req: got %b expected 1", imem_req); end
        if (imem_addr !== 32'h3000) begin miscompares++; $display("FAIL rst_first_addr: got %h expected 00003000", imem_addr); end
        step();
    endtask

    task automatic test_zero_wait();
        logic [31:0] a;
        reset_dut();
        for (int i = 0; i < 4; i++) begin
            a = 32'h3000 + 32'(4 * i);
            #1;
            vectors += 2;
            if (imem_req !== 1'b1) begin miscompares++; $display("FAIL zw_req: got %b expected 1", imem_req); end
            if (imem_addr !== a) begin miscompares++; $display("FAIL zw_addr: got %h expected %h", imem_addr, a); end
            step();
            vectors += 2;
            if (F_PC !== a) begin miscompares++; $display("FAIL zw_fpc: got %h expected %h", F_PC, a); end
            if (F_valid !== 1'b1) begin miscompares++; $display("FAIL zw_valid: got %b expected 1", F_valid); end
        end
    endtask

    task automatic test_stall();
        reset_dut();
        step();
        step();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            vectors++;
            if (imem_req !== 1'b0) begin miscompares++; $display("FAIL st_req: got %b expected 0", imem_req); end
            step();
            vectors += 2;
            if (F_PC !== 32'h3004) begin miscompares++; $display("FAIL st_fpc: got %h expected 00003004", F_PC); end
            if (F_Instruction !== inst_of(32'h3004)) begin
                miscompares++; $display("FAIL st_inst: got %h expected %h", F_Instruction, inst_of(32'h3004));
            end
        end
        stall = 1'b0;
        #1;
        vectors += 2;
        if (imem_req !== 1'b1) begin miscompares++; $display("FAIL st_rel_req: got %b expected 1", imem_req); end
        if (imem_addr !== 32'h3008) begin miscompares++; $display("FAIL st_rel_addr: got %h expected 00003008", imem_addr); end
        step();
        vectors++;
        if (F_PC !== 32'h3008) begin miscompares++; $display("FAIL st_rel_fpc: got %h expected 00003008", F_PC); end
    endtask

    task automatic test_latency();
        logic [31:0] a;
        reset_dut();
        lat = 2;
        for (int i = 0; i < 9; i++) begin
            a = 32'h3000 + 32'(4 * (i / 3));
            #1;
            vectors += 2;
            if (imem_req !== 1'b1) begin miscompares++; $display("FAIL lat_req: got %b expected 1", imem_req); end
            if (imem_addr !== a) begin miscompares++; $display("FAIL lat_addr: got %h expected %h", imem_addr, a); end
            step();
            vectors++;
            if (F_valid !== (i % 3 == 2)) begin
                miscompares++; $display("FAIL lat_valid: got %b expected %b", F_valid, i % 3 == 2);
            end
        end
    endtask

    task automatic test_redirect_drop();
        reset_dut();
        step(); step(); step();
        lat = 3;
        #1;
        vectors++;
        if (imem_addr !== 32'h300C) begin miscompares++; $display("FAIL rd_addr_a: got %h expected 0000300c", imem_addr); end
        step();
        redirect_valid = 1'b1; redirect_pc = 32'h3100;
        #1;
        vectors += 2;
        if (imem_req !== 1'b1) begin miscompares++; $display("FAIL rd_req_b: got %b expected 1", imem_req); end
        if (imem_addr !== 32'h300C) begin miscompares++; $display("FAIL rd_addr_b: got %h expected 0000300c", imem_addr); end
        step();
        redirect_pc = 32'h3200;
        #1;
        vectors += 2;
        if (imem_req !== 1'b1) begin miscompares++; $display("FAIL rd_req_c: got %b expected 1", imem_req); end
        if (imem_addr !== 32'h300C) begin miscompares++; $display("FAIL rd_addr_c: got %h expected 0000300c", imem_addr); end
        step();
        redirect_valid = 1'b0;
        #1;
        vectors += 2;
        if (imem_req !== 1'b1) begin miscompares++; $display("FAIL rd_req_d: got %b expected 1", imem_req); end
        if (imem_addr !== 32'h300C) begin miscompares++; $display("FAIL rd_addr_d: got %h expected 0000300c", imem_addr); end
        step();
        #1;
        vectors += 3;
        if (F_valid !== 1'b0) begin miscompares++; $display("FAIL rd_drop_valid: got %b expected 0", F_valid); end
        if (imem_req !== 1'b1) begin miscompares++; $display("FAIL rd_req_e: got %b expected 1", imem_req); end
        if (imem_addr !== 32'h3200) begin miscompares++; $display("FAIL rd_addr_e: got %h expected 00003200", imem_addr); end
        lat = 0;
        step();
        vectors++;
        if (F_PC !== 32'h3200) begin miscompares++; $display("FAIL rd_fpc: got %h expected 00003200", F_PC); end
    endtask

    task automatic test_redirect_on_ack();
        reset_dut();
        step(); step(); step(); step();
        lat = 1;
        #1;
        vectors++;
        if (imem_addr !== 32'h3010) begin miscompares++; $display("FAIL ra_addr_x: got %h expected 00003010", imem_addr); end
        step();
        redirect_valid = 1'b1; redirect_pc = 32'h3102;
        #1;
        vectors += 2;
        if (imem_req !== 1'b1) begin miscompares++; $display("FAIL ra_req_y: got %b expected 1", imem_req); end
        if (imem_addr !== 32'h3010) begin miscompares++; $display("FAIL ra_addr_y: got %h expected 00003010", imem_addr); end
        step();
        redirect_valid = 1'b0;
        #1;
        vectors += 4;
        if (F_valid !== 1'b0) begin miscompares++; $display("FAIL ra_valid: got %b expected 0", F_valid); end
        if (F_Instruction !== 32'h0) begin miscompares++; $display("FAIL ra_inst: got %h expected 0", F_Instruction); end
        if (imem_req !== 1'b1) begin miscompares++; $display("FAIL ra_req_z: got %b expected 1", imem_req); end
        if (imem_addr !== 32'h3100) begin miscompares++; $display("FAIL ra_addr_z: got %h expected 00003100", imem_addr); end
        lat = 0;
        step();
        vectors += 2;
        if (F_PC !== 32'h3100) begin miscompares++; $display("FAIL ra_fpc: got %h expected 00003100", F_PC); end
        if (F_Instruction !== inst_of(32'h3100)) begin
            miscompares++; $display("FAIL ra_finst: got %h expected %h", F_Instruction, inst_of(32'h3100));
        end
    endtask

    task automatic test_reset_mid();
        reset_dut();
        step(); step();
        lat = 3;
        step();
        reset = 1'b1;
        #1;
        vectors++;
        if (imem_req !== 1'b0) begin miscompares++; $display("FAIL rm_req_in: got %b expected 0", imem_req); end
        step();
        vectors += 4;
        if (imem_req !== 1'b0) begin miscompares++; $display("FAIL rm_req: got %b expected 0", imem_req); end
        if (F_Instruction !== 32'h0) begin miscompares++; $display("FAIL rm_inst: got %h expected 0", F_Instruction); end
        if (F_PC !== 32'h0) begin miscompares++; $display("FAIL rm_fpc: got %h expected 0", F_PC); end
        if (F_valid !== 1'b0) begin miscompares++; $display("FAIL rm_valid: got %b expected 0", F_valid); end
        reset = 1'b0;
        #1;
        vectors += 2;
        if (imem_req !== 1'b1) begin miscompares++; $display("FAIL rm_req_post: got %b expected 1", imem_req); end
        if (imem_addr !== 32'h3000) begin miscompares++; $display("FAIL rm_addr_post: got %h expected 00003000", imem_addr); end
        lat = 0;
        step();
        vectors++;
        if (F_PC !== 32'h3000) begin miscompares++; $display("FAIL rm_fpc_post: got %h expected 00003000", F_PC); end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_stall();
        test_latency();
        test_redirect_drop();
        test_redirect_on_ack();
        test_reset_mid();
        step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
